// File: rtl/axi4_read_arbiter.sv
// Two-master AXI4 read arbiter (fetch m0, load m1) with one outstanding read.
// Define ARB_ROUND_ROBIN_EN for round-robin ties; otherwise m1 wins every tie.
module axi4_read_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req,
    input  logic [63:0] m0_addr,
    output logic [63:0] m0_rdata,
    output logic        m0_done,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic [63:0] m1_addr,
    output logic [63:0] m1_rdata,
    output logic        m1_done,
    output logic        m1_err,
    output logic [63:0] AR_ADDR,
    output logic        AR_VALID,
    output logic [2:0]  AR_PROT,
    input  logic        AR_READY,
    input  logic [63:0] R_DATA,
    input  logic [1:0]  R_RESP,
    input  logic        R_VALID,
    output logic        R_READY
);
    localparam int unsigned AddrW = 64;
    localparam int unsigned DataW = 64;
    localparam int unsigned ProtW = 3;
    localparam logic [ProtW-1:0] ProtFetch = ProtW'(3'b100);
    localparam logic [ProtW-1:0] ProtLoad  = ProtW'(3'b000);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_e;

    state_e             state_q;
    logic               grant_q;       // 1 = m1 owns the current transfer
    logic               last_grant_q;  // 1 = m1 was granted last
    logic [AddrW-1:0]   ar_addr_q;
    logic [ProtW-1:0]   ar_prot_q;
    logic               ar_valid_q;
    logic               r_ready_q;
    logic [DataW-1:0]   m0_rdata_q, m1_rdata_q;
    logic               m0_done_q, m1_done_q, m0_err_q, m1_err_q;
    logic               pick_m1_c;

    // Arbitration decision for the IDLE cycle
    always_comb begin
        pick_m1_c = 1'b0;
        if (m1_req && !m0_req) begin
            pick_m1_c = 1'b1;
        end else if (m1_req && m0_req) begin
`ifdef ARB_ROUND_ROBIN_EN
            pick_m1_c = ~last_grant_q;
`else
            pick_m1_c = 1'b1;
`endif
        end
    end

`ifndef ARB_ROUND_ROBIN_EN
    logic unused_last_grant_c;
    assign unused_last_grant_c = last_grant_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            ar_addr_q    <= '0;
            ar_prot_q    <= '0;
            ar_valid_q   <= 1'b0;
            r_ready_q    <= 1'b0;
            m0_rdata_q   <= '0;
            m1_rdata_q   <= '0;
            m0_done_q    <= 1'b0;
            m1_done_q    <= 1'b0;
            m0_err_q     <= 1'b0;
            m1_err_q     <= 1'b0;
        end else begin
            m0_done_q <= 1'b0;
            m1_done_q <= 1'b0;
            m0_err_q  <= 1'b0;
            m1_err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (m0_req || m1_req) begin
                        grant_q    <= pick_m1_c;
                        ar_addr_q  <= pick_m1_c ? m1_addr : m0_addr;
                        ar_prot_q  <= pick_m1_c ? ProtLoad : ProtFetch;
                        ar_valid_q <= 1'b1;
                        state_q    <= ADDR;
                    end
                end
                ADDR: begin
                    if (AR_READY) begin
                        ar_valid_q <= 1'b0;
                        r_ready_q  <= 1'b1;
                        state_q    <= DATA;
                    end
                end
                DATA: begin
                    // Response goes straight into the granted requester's registers
                    if (R_VALID) begin
                        r_ready_q <= 1'b0;
                        if (grant_q) begin
                            m1_rdata_q <= R_DATA;
                            m1_done_q  <= 1'b1;
                            m1_err_q   <= (R_RESP != 2'b00);
                        end else begin
                            m0_rdata_q <= R_DATA;
                            m0_done_q  <= 1'b1;
                            m0_err_q   <= (R_RESP != 2'b00);
                        end
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    last_grant_q <= grant_q;
                    state_q      <= IDLE;
                end
            endcase
        end
    end

    assign AR_ADDR  = ar_addr_q;
    assign AR_PROT  = ar_prot_q;
    assign AR_VALID = ar_valid_q;
    assign R_READY  = r_ready_q;
    assign m0_rdata = m0_rdata_q;
    assign m1_rdata = m1_rdata_q;
    assign m0_done  = m0_done_q;
    assign m1_done  = m1_done_q;
    assign m0_err   = m0_err_q;
    assign m1_err   = m1_err_q;
endmodule
